// File: rtl/lutram_stress_pkg.sv
// Shared types and constants for the LUTRAM stress sequencer and its pattern generator.
package lutram_stress_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int NUM_PASSES_DEF = 4;

  localparam logic [9:0] CHECKER_PAT = 10'h155;

  // Fibonacci LFSR for x^10 + x^7 + 1: feedback taken from bits 9 and 6.
  localparam int         LFSR_W      = 10;
  localparam logic [9:0] LFSR_SEED   = 10'h001;
  localparam int         LFSR_TAP_HI = 9;
  localparam int         LFSR_TAP_LO = 6;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], cur[LFSR_TAP_HI] ^ cur[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/lutram_stress_seq_pattern_gen.sv
// Pattern source shared by the write and read phases; owns the per-word LFSR.
module lutram_pattern_gen
  import lutram_stress_pkg::*;
#(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        pass,
  input  logic              addr_lsb,
  input  logic              advance,
  input  logic              reseed,
  output logic [DATA_W-1:0] pattern
);

  logic [LFSR_W-1:0] lfsr;
  logic [DATA_W-1:0] checker_word;

  // Reseed wins so every pass restarts the sequence at the seed for word 0.
  always_ff @(posedge clk) begin
    if (rst || reseed) begin
      lfsr <= LFSR_SEED;
    end else if (advance) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign checker_word = DATA_W'(CHECKER_PAT) ^ {DATA_W{addr_lsb}};

  always_comb begin
    pattern = '0;
    case (pass)
      2'd0:    pattern = checker_word;
      2'd1:    pattern = ~checker_word;
      2'd2:    pattern = DATA_W'(lfsr);
      default: pattern = ~DATA_W'(lfsr);
    endcase
  end

endmodule

// File: rtl/lutram_stress_seq.sv
// Write/read-back stress sequencer for the 16x10 LUTRAM.
// Optional LUTRAM_STRESS_FAULT_INJECT_EN adds fault_inj, which flips write-data bit 0.
module lutram_stress_seq
  import lutram_stress_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 10,
  parameter int NUM_PASSES = NUM_PASSES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass_ok,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdat,
  output state_t            state_dbg,
  input  logic [DATA_W-1:0] mem_rdat
`ifdef LUTRAM_STRESS_FAULT_INJECT_EN
  ,
  input  logic              fault_inj
`endif
);

  localparam logic [1:0] LAST_PASS = 2'(NUM_PASSES - 1);

  state_t            state;
  logic [1:0]        pass;
  logic [ADDR_W-1:0] addr;
  logic              first_seen;
  logic [DATA_W-1:0] pattern;
  logic [DATA_W-1:0] wdat_mod;
  logic              in_write;
  logic              in_read;
  logic              last_addr;
  logic              mismatch;
  logic              start_acc;

  assign in_write  = (state == ST_WRITE);
  assign in_read   = (state == ST_READ);
  assign last_addr = (addr == {ADDR_W{1'b1}});
  assign start_acc = (state == ST_IDLE) && start;
  assign mismatch  = in_read && (mem_rdat != pattern);

  lutram_pattern_gen #(
    .DATA_W (DATA_W)
  ) u_pattern_gen (
    .clk      (clk),
    .rst      (rst),
    .pass     (pass),
    .addr_lsb (addr[0]),
    .advance  ((in_write || in_read) && !last_addr),
    .reseed   (start_acc || ((in_write || in_read) && last_addr)),
    .pattern  (pattern)
  );

`ifdef LUTRAM_STRESS_FAULT_INJECT_EN
  assign wdat_mod = pattern ^ {{(DATA_W-1){1'b0}}, fault_inj};
`else
  assign wdat_mod = pattern;
`endif

  assign mem_addr  = addr;
  assign mem_we    = in_write;
  assign mem_wdat  = in_write ? wdat_mod : '0;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      pass           <= 2'd0;
      addr           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass_ok        <= 1'b0;
      err_cnt        <= 16'd0;
      first_err_addr <= '0;
      first_seen     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state          <= ST_WRITE;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass_ok        <= 1'b0;
            err_cnt        <= 16'd0;
            first_err_addr <= '0;
            first_seen     <= 1'b0;
            pass           <= 2'd0;
            addr           <= '0;
          end
        end
        ST_WRITE: begin
          addr <= addr + 1'b1;
          if (last_addr) begin
            state <= ST_READ;
          end
        end
        ST_READ: begin
          addr <= addr + 1'b1;
          if (mismatch) begin
            if (err_cnt != 16'hFFFF) begin
              err_cnt <= err_cnt + 16'd1;
            end
            if (!first_seen) begin
              first_err_addr <= addr;
              first_seen     <= 1'b1;
            end
          end
          if (last_addr) begin
            if (pass == LAST_PASS) begin
              // Fold in this cycle's compare so pass_ok covers the final word.
              state   <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass_ok <= (err_cnt == 16'd0) && !mismatch;
            end else begin
              state <= ST_WRITE;
              pass  <= pass + 2'd1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
